// File: rtl/uart_mm_loader_if.sv
// Signal bundle between the UART byte source, the operand memories and the
// multiply engine; the loader takes the master side.
interface uart_mm_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_byte;
  logic              rx_status;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        dim;
  logic              mm_start;
  logic              mm_done;
  logic              busy;
  logic              job_done;
  logic              err_dim;
  logic              err_checksum;
  logic              err_timeout;

  modport master (
    input  rx_byte, rx_status, mm_done,
    output mem_we, mem_sel, mem_addr, mem_wdata, dim, mm_start, busy,
           job_done, err_dim, err_checksum, err_timeout
  );

  modport slave (
    output rx_byte, rx_status, mm_done,
    input  mem_we, mem_sel, mem_addr, mem_wdata, dim, mm_start, busy,
           job_done, err_dim, err_checksum, err_timeout
  );
endinterface

// File: rtl/uart_mm_loader.sv
// Parses HEADER / N / A[N*N] / B[N*N] / XOR-checksum packets from the UART,
// fills the operand memories, then launches the multiply engine.
module uart_mm_loader #(
  parameter int         MAX_N   = 8,
  parameter int         ADDR_W  = 6,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  uart_mm_loader_if.master bus
);
  localparam int                CNT_W     = ADDR_W + 1;
  localparam int                IDLE_W    = $clog2(TIMEOUT) + 1;
  localparam logic [7:0]        MAX_N_B   = 8'(MAX_N);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIM, S_LOAD_A, S_LOAD_B, S_CHECK, S_START, S_WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              rx_q, rx_d;
  logic [CNT_W-1:0]  elem_cnt_q, elem_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]        dim_q, dim_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mm_start_q, mm_start_d;
  logic              job_done_q, job_done_d;
  logic              err_dim_q, err_dim_d;
  logic              err_cs_q, err_cs_d;
  logic              err_to_q, err_to_d;

  logic             byte_evt;
  logic             in_pkt;
  logic [CNT_W-1:0] nn;
  logic             last_elem;

  assign byte_evt  = bus.rx_status & ~rx_q;
  assign in_pkt    = (state_q == S_DIM) || (state_q == S_LOAD_A) ||
                     (state_q == S_LOAD_B) || (state_q == S_CHECK);
  assign nn        = CNT_W'(dim_q) * CNT_W'(dim_q);
  assign last_elem = (elem_cnt_q == nn - 1'b1);

  always_comb begin
    state_d     = state_q;
    rx_d        = bus.rx_status;
    elem_cnt_d  = elem_cnt_q;
    csum_d      = csum_q;
    dim_d       = dim_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mm_start_d  = 1'b0;
    job_done_d  = 1'b0;
    err_dim_d   = err_dim_q;
    err_cs_d    = err_cs_q;
    err_to_d    = err_to_q;
    idle_cnt_d  = (in_pkt && !byte_evt) ? idle_cnt_q + 1'b1 : '0;

    case (state_q)
      S_IDLE: begin
        if (byte_evt && bus.rx_byte == HEADER) begin
          err_dim_d = 1'b0;
          err_cs_d  = 1'b0;
          err_to_d  = 1'b0;
          state_d   = S_DIM;
        end
      end
      S_DIM: begin
        if (byte_evt) begin
          if (bus.rx_byte != 8'd0 && bus.rx_byte <= MAX_N_B) begin
            dim_d      = bus.rx_byte;
            elem_cnt_d = '0;
            csum_d     = 8'd0;
            state_d    = S_LOAD_A;
          end else begin
            err_dim_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (byte_evt) begin
          mem_we_d    = 1'b1;
          mem_sel_d   = (state_q == S_LOAD_B);
          mem_addr_d  = elem_cnt_q[ADDR_W-1:0];
          mem_wdata_d = bus.rx_byte;
          csum_d      = csum_q ^ bus.rx_byte;
          if (last_elem) begin
            elem_cnt_d = '0;
            state_d    = (state_q == S_LOAD_A) ? S_LOAD_B : S_CHECK;
          end else begin
            elem_cnt_d = elem_cnt_q + 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (byte_evt) begin
          if (bus.rx_byte == csum_q) begin
            state_d = S_START;
          end else begin
            err_cs_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_START: begin
        mm_start_d = 1'b1;
        state_d    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // mm_start is still high on the first WAIT_DONE cycle; a done there is stale
        if (bus.mm_done && !mm_start_q) begin
          job_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte arriving on the expiry cycle takes priority over the timeout
    if (in_pkt && !byte_evt && idle_cnt_q == IDLE_LAST) begin
      err_to_d = 1'b1;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rx_q        <= 1'b1;
      elem_cnt_q  <= '0;
      csum_q      <= 8'd0;
      idle_cnt_q  <= '0;
      dim_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      mm_start_q  <= 1'b0;
      job_done_q  <= 1'b0;
      err_dim_q   <= 1'b0;
      err_cs_q    <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      elem_cnt_q  <= elem_cnt_d;
      csum_q      <= csum_d;
      idle_cnt_q  <= idle_cnt_d;
      dim_q       <= dim_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mm_start_q  <= mm_start_d;
      job_done_q  <= job_done_d;
      err_dim_q   <= err_dim_d;
      err_cs_q    <= err_cs_d;
      err_to_q    <= err_to_d;
    end
  end

  assign bus.mem_we       = mem_we_q;
  assign bus.mem_sel      = mem_sel_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.dim          = dim_q;
  assign bus.mm_start     = mm_start_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.job_done     = job_done_q;
  assign bus.err_dim      = err_dim_q;
  assign bus.err_checksum = err_cs_q;
  assign bus.err_timeout  = err_to_q;
endmodule

// File: doc/uart_mm_loader.md
# uart_mm_loader

Byte-stream controller between the UART receiver and the tiled matrix-multiply engine. It takes one received byte per receiver status rising edge and parses a framed packet: header, dimension N, N×N bytes of matrix A, N×N bytes of matrix B, and an XOR checksum. It writes A and B into the operand memories, then starts the multiply engine and waits for its completion. It also flags framing, dimension, checksum and inter-byte timeout errors.

## Interface
- MAX_N, 8: largest supported square dimension.
- ADDR_W, 6: operand memory address width; must satisfy 2^ADDR_W ≥ MAX_N*MAX_N.
- HEADER, 8'hA5: packet start byte.
- TIMEOUT, 1024: maximum idle cycles between bytes inside a packet.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- rx_byte  in  8  receiver parallel data; valid when rx_status rises.
- rx_status  in  1  receiver data-available level.
- mem_we  out  1  operand memory write strobe, one cycle per element.
- mem_sel  out  1  0 = matrix A memory, 1 = matrix B memory.
- mem_addr  out  ADDR_W  element address, row-major: row*N + col.
- mem_wdata  out  8  element value.
- dim  out  8  latched N of the last accepted packet.
- mm_start  out  1  one-cycle start pulse to the multiply engine.
- mm_done  in  1  engine completion pulse.
- busy  out  1  high in every state except IDLE.
- job_done  out  1  one-cycle pulse after mm_done is accepted.
- err_dim, err_checksum, err_timeout  out  1 each  sticky error flags.

## Operation
**Byte event**
- rx_q is a register that holds the previous rx_status. Its reset value is 1, so a receiver status that is already high at reset release does not create a false event.
- byte_evt = rx_status & ~rx_q. Each event consumes exactly one rx_byte.

**FSM states:** IDLE, DIM, LOAD_A, LOAD_B, CHECK, START, WAIT_DONE.
- IDLE
  - On a byte_evt with byte == HEADER: clear all three error flags, go to DIM.
  - Any other byte is ignored.
- DIM
  - Byte in 1..MAX_N: latch it into dim, clear elem_cnt and csum, go to LOAD_A.
  - Byte of 0 or greater than MAX_N: set err_dim, go to IDLE; dim is unchanged.
- LOAD_A
  - Each byte_evt writes the byte to mem_sel=0 at addr=elem_cnt, XORs it into csum, and increments elem_cnt.
  - After element N*N-1: clear elem_cnt, go to LOAD_B.
- LOAD_B
  - Same as LOAD_A with mem_sel=1.
  - After the last element: go to CHECK.
- CHECK
  - Byte equal to csum: go to START.
  - Otherwise: set err_checksum, go to IDLE. Memory already written is left as is.
- START: mm_start=1 for one cycle, then go to WAIT_DONE.
- WAIT_DONE: on mm_done, pulse job_done and go to IDLE.

**Timeout**
- In DIM, LOAD_A, LOAD_B and CHECK, idle_cnt increments every cycle and clears on each byte_evt.
- When idle_cnt reaches TIMEOUT-1 without an event: set err_timeout, go to IDLE.

**Ignored inputs**
- Bytes arriving in START or WAIT_DONE are dropped.
- mm_done outside WAIT_DONE is ignored.

**Arithmetic**
- elem_cnt is ADDR_W+1 bits wide; N*N is computed at the width of elem_cnt.
- csum is 8 bits, XOR over all 2*N*N data bytes. Header, dim and checksum bytes are excluded.

## Timing
**Reset values**
- mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, dim=0.
- mm_start=0, busy=0, job_done=0, all error flags 0, state=IDLE, rx_q=1.
- A reset asserted mid-packet returns everything to these values at the next edge. No further writes occur and the rest of the packet is ignored until a new HEADER arrives.

**Latencies** (byte_evt in cycle k)
- mem_we, mem_sel, mem_addr and mem_wdata are all registered and valid in cycle k+1 for exactly one cycle.
- Error flags and state change are visible in cycle k+1.
- Checksum match at cycle k: mm_start is high in cycle k+2.
- mm_done high in cycle j while in WAIT_DONE: job_done is high in cycle j+1, and busy is low from cycle j+1.

**Simultaneous and edge cases**
- mm_done in the same cycle as mm_start is not accepted; WAIT_DONE begins sampling the cycle after mm_start.
- At most one byte_evt per cycle, by construction.
- A timeout expiring in the same cycle as a byte_evt: the byte wins and the timeout is not taken.

## Test plan
- N=2 packet A5 02 01 02 03 04 05 06 07 08 08 (checksum = 0x08):
  - A writes addr 0..3 = 01..04 and B writes addr 0..3 = 05..08, one mem_we each.
  - mm_start fires once; after an mm_done pulse, job_done fires once and dim=2.
- Dimension byte 00, then a separate packet with 09 (MAX_N=8): err_dim=1, no mem_we, back in IDLE. The next A5 header clears err_dim.
- N=1 packet A5 01 11 22 FF (correct checksum 0x33): err_checksum=1, two writes occurred, mm_start never asserts.
- Send A5 01 11, then idle 1024 cycles: err_timeout=1, busy=0. A later 22 byte causes no write.
- Hold rx_status high through reset release, then send a full valid N=1 packet: no spurious write before the header, the packet completes normally, and stray bytes and mm_done pulses while in IDLE have no effect.
- Assert reset during LOAD_B of an N=3 packet: all outputs return to reset values the next cycle, and a following N=1 packet completes correctly.
